// File: rtl/ctrl_port_arbiter_if.sv
// Controller-port bundle: CPU side, pad side and poller status between the arbiter and its users.
// slave = arbiter view, master = requester/pad/bench view.
interface ctrl_port_arbiter_if;
  logic       cpu_strobe;
  logic [1:0] cpu_shift;
  logic [1:0] cpu_data;
  logic       pad_strobe;
  logic [1:0] pad_clk;
  logic [1:0] pad_data;
  logic       poll_req;
  logic       poll_busy;
  logic       poll_done;
  logic       poll_err;
  logic [7:0] buttons0;
  logic [7:0] buttons1;

  modport slave (
    input  cpu_strobe, cpu_shift, pad_data, poll_req,
    output cpu_data, pad_strobe, pad_clk, poll_busy, poll_done, poll_err, buttons0, buttons1
  );

  modport master (
    output cpu_strobe, cpu_shift, pad_data, poll_req,
    input  cpu_data, pad_strobe, pad_clk, poll_busy, poll_done, poll_err, buttons0, buttons1
  );
endinterface

// File: rtl/ctrl_port_arbiter.sv
// Shares two NES pad ports between CPU pass-through (1-cycle registered pad drive) and a poller
// that strobes/shifts both pads and publishes 8 buttons per port; CPU strobe mid-poll aborts it.
module ctrl_port_arbiter #(
  parameter int CLK_DIV       = 96,
  parameter int STROBE_CYCLES = 12,
  parameter int GUARD_CYCLES  = 64,
  parameter int AUTO_PERIOD   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  ctrl_port_arbiter_if.slave    bus
);
  localparam int PMAX      = (CLK_DIV > STROBE_CYCLES) ? CLK_DIV : STROBE_CYCLES;
  localparam int CW        = $clog2(PMAX);
  localparam int GW        = $clog2(GUARD_CYCLES + 1);
  localparam int AW        = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
  localparam int AUTO_LAST = (AUTO_PERIOD > 0) ? AUTO_PERIOD - 1 : 0;
  localparam bit AUTO_EN   = (AUTO_PERIOD > 0);

  typedef enum logic [2:0] {IDLE, STROBE, LOW, HIGH, DONE} state_t;

  state_t        state;
  logic [CW-1:0] phase;
  logic [2:0]    bit_idx;
  logic [GW-1:0] idle_cnt;
  logic [AW-1:0] auto_cnt;
  logic          pending;
  logic [7:0]    shadow0, shadow1;
  logic [7:0]    cap0, cap1;
  logic [1:0]    shift_q;

  logic          cpu_active, auto_tick, polling, grant;
  logic [1:0]    shift_rise;
  logic [7:0]    cap0_nxt, cap1_nxt;

  always_comb begin
    cpu_active = bus.cpu_strobe || (bus.cpu_shift != 2'b00);
    auto_tick  = AUTO_EN && (auto_cnt == AW'(AUTO_LAST));
    polling    = (state == STROBE) || (state == LOW) || (state == HIGH);
    grant      = (state == IDLE) && pending && (idle_cnt == GW'(GUARD_CYCLES));
    shift_rise = bus.cpu_shift & ~shift_q;
    cap0_nxt   = cap0;
    cap1_nxt   = cap1;
    cap0_nxt[bit_idx] = ~bus.pad_data[0];
    cap1_nxt[bit_idx] = ~bus.pad_data[1];
  end

  // While the poller owns the pads the CPU reads the previous result, like a real pad would.
  assign bus.cpu_data = polling ? {shadow1[0], shadow0[0]} : ~bus.pad_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      phase          <= '0;
      bit_idx        <= '0;
      idle_cnt       <= '0;
      auto_cnt       <= '0;
      pending        <= 1'b0;
      shadow0        <= '0;
      shadow1        <= '0;
      cap0           <= '0;
      cap1           <= '0;
      shift_q        <= '0;
      bus.pad_strobe <= 1'b0;
      bus.pad_clk    <= 2'b00;
      bus.poll_busy  <= 1'b0;
      bus.poll_done  <= 1'b0;
      bus.poll_err   <= 1'b0;
      bus.buttons0   <= '0;
      bus.buttons1   <= '0;
    end else begin
      shift_q       <= bus.cpu_shift;
      bus.poll_done <= 1'b0;
      bus.poll_err  <= 1'b0;

      if (cpu_active)
        idle_cnt <= '0;
      else if (idle_cnt != GW'(GUARD_CYCLES))
        idle_cnt <= idle_cnt + 1'b1;

      if (AUTO_EN)
        auto_cnt <= auto_tick ? '0 : auto_cnt + 1'b1;

      // A request in the grant cycle re-arms pending so a follow-up poll runs.
      if (bus.poll_req || auto_tick)
        pending <= 1'b1;
      else if (grant)
        pending <= 1'b0;

      if (polling) begin
        if (shift_rise[0]) shadow0 <= {1'b1, shadow0[7:1]};
        if (shift_rise[1]) shadow1 <= {1'b1, shadow1[7:1]};
      end

      if (polling && bus.cpu_strobe) begin
        state          <= DONE;
        bus.pad_strobe <= 1'b0;
        bus.pad_clk    <= 2'b00;
        bus.poll_done  <= 1'b1;
        bus.poll_err   <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            bus.pad_strobe <= bus.cpu_strobe;
            bus.pad_clk    <= bus.cpu_shift;
            if (grant) begin
              state          <= STROBE;
              phase          <= '0;
              bus.pad_strobe <= 1'b1;
              bus.pad_clk    <= 2'b00;
              bus.poll_busy  <= 1'b1;
              shadow0        <= bus.buttons0;
              shadow1        <= bus.buttons1;
            end
          end
          STROBE: begin
            if (phase == CW'(STROBE_CYCLES - 1)) begin
              state          <= LOW;
              phase          <= '0;
              bit_idx        <= '0;
              bus.pad_strobe <= 1'b0;
            end else begin
              phase <= phase + 1'b1;
            end
          end
          LOW: begin
            if (phase == CW'(CLK_DIV - 1)) begin
              phase <= '0;
              cap0  <= cap0_nxt;
              cap1  <= cap1_nxt;
              if (bit_idx == 3'd7) begin
                state         <= DONE;
                bus.buttons0  <= cap0_nxt;
                bus.buttons1  <= cap1_nxt;
                bus.poll_done <= 1'b1;
              end else begin
                state       <= HIGH;
                bus.pad_clk <= 2'b11;
              end
            end else begin
              phase <= phase + 1'b1;
            end
          end
          HIGH: begin
            if (phase == CW'(CLK_DIV - 1)) begin
              state       <= LOW;
              phase       <= '0;
              bit_idx     <= bit_idx + 3'd1;
              bus.pad_clk <= 2'b00;
            end else begin
              phase <= phase + 1'b1;
            end
          end
          DONE: begin
            state          <= IDLE;
            bus.poll_busy  <= 1'b0;
            bus.pad_strobe <= bus.cpu_strobe;
            bus.pad_clk    <= bus.cpu_shift;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
